// File: rtl/rom_loader_if.sv
// -----------------------------------------------------------------------------
// rom_loader_if
// Memory-write bus between the ROM loader and the memory controller.
//   mem_req  : write request level; held with mem_addr/mem_din until acknowledged
//   mem_addr : 24-bit byte address of the request
//   mem_din  : 16-bit write data of the request
//   mem_ack  : one-cycle completion pulse from the memory controller
// Handshake: the master raises mem_req with stable address/data and keeps all
// three stable until it samples mem_ack high on a rising edge; on that edge the
// request completes and mem_req drops. mem_ack is ignored while mem_req is low.
// -----------------------------------------------------------------------------
interface rom_loader_if;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_ack;

    modport master (output mem_req, output mem_addr, output mem_din, input mem_ack);
    modport slave  (input mem_req, input mem_addr, input mem_din, output mem_ack);
endinterface

// File: rtl/rom_loader.sv
// -----------------------------------------------------------------------------
// rom_loader
// Streams a ROM download from the ioctl loader interface into memory through a
// small word FIFO, optionally skipping a copier header, and computes an address
// mask for the loaded payload.
// Ports:
//   clk_sys, reset_n          : system clock, async active-low reset
//   ioctl_download/index/wr/addr/dout/filesize : loader interface inputs
//   mem (rom_loader_if.master): memory write bus (req/addr/din out, ack in)
//   loading                   : high while in LOAD or DRAIN
//   ready                     : high in DONE; rom_mask is valid
//   rom_mask                  : bit-smear of (payload size - 1)
//   overflow                  : sticky, a word was dropped on a full FIFO
//   dbg_state_o               : current FSM state (IDLE=0 LOAD=1 DRAIN=2 DONE=3)
// -----------------------------------------------------------------------------
module rom_loader #(
    parameter logic [7:0] ROM_INDEX  = 8'h00,
    parameter int         FIFO_DEPTH = 4,
    parameter int         HDR_SIZE   = 512
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    input  logic [23:0] ioctl_filesize,
    rom_loader_if.master mem,
    output logic        loading,
    output logic        ready,
    output logic [23:0] rom_mask,
    output logic        overflow,
    output logic [1:0]  dbg_state_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t      state_q;
    logic        dl_prev_q, start_q, pend_q, hdr_q;
    logic [23:0] fsize_q;
    logic [39:0] fifo_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        mem_req_q, loading_q, ready_q, overflow_q;
    logic [23:0] mem_addr_q, rom_mask_q;
    logic [15:0] mem_din_q;

    logic        start_edge, fall_edge, accept, hdr_new;
    logic        fifo_empty, fifo_full, active, pop, want_push, push, drop;
    logic [24:0] offset, addr_rel;
    logic [23:0] payload, payload_m1, mask_d;

    assign start_edge = ioctl_download && !dl_prev_q && (ioctl_index == ROM_INDEX);
    assign fall_edge  = dl_prev_q && !ioctl_download;
    // A start seen during DRAIN is remembered in pend_q and taken up in DONE.
    assign accept     = (start_q || pend_q) && (state_q == IDLE || state_q == DONE);
    assign hdr_new    = ({14'd0, ioctl_filesize[9:0]} == 24'(HDR_SIZE));

    assign offset     = hdr_q ? 25'(HDR_SIZE) : 25'd0;
    assign addr_rel   = ioctl_addr - offset;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign active     = (state_q == LOAD) || (state_q == DRAIN);
    assign pop        = active && !mem_req_q && !fifo_empty;
    assign want_push  = (state_q == LOAD) && ioctl_wr && (ioctl_addr >= offset);
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push       = want_push && (!fifo_full || pop);
    assign drop       = want_push && fifo_full && !pop;

    // Payload mask: every bit at and below the MSB of (P-1); zero for P==0.
    assign payload    = fsize_q - (hdr_q ? 24'(HDR_SIZE) : 24'd0);
    assign payload_m1 = payload - 24'd1;
    always_comb begin
        mask_d = '0;
        if (payload != 24'd0) begin
            for (int i = 0; i < 24; i++) begin
                mask_d[i] = |(payload_m1 >> i);
            end
        end
    end

    // FIFO storage carries no reset; emptiness is defined by the pointers.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= {addr_rel[23:0], ioctl_dout};
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            dl_prev_q  <= 1'b0;
            start_q    <= 1'b0;
            pend_q     <= 1'b0;
            hdr_q      <= 1'b0;
            fsize_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            loading_q  <= 1'b0;
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
            rom_mask_q <= '0;
        end else begin
            dl_prev_q <= ioctl_download;
            start_q   <= start_edge;

            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (drop) overflow_q <= 1'b1;

            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                mem_req_q  <= 1'b1;
                mem_addr_q <= fifo_q[rd_ptr_q[AW-1:0]][39:16];
                mem_din_q  <= fifo_q[rd_ptr_q[AW-1:0]][15:0];
            end else if (mem_req_q && mem.mem_ack) begin
                mem_req_q <= 1'b0;
            end

            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        state_q    <= LOAD;
                        wr_ptr_q   <= '0;
                        rd_ptr_q   <= '0;
                        overflow_q <= 1'b0;
                        ready_q    <= 1'b0;
                        loading_q  <= 1'b1;
                        pend_q     <= 1'b0;
                        hdr_q      <= hdr_new;
                        fsize_q    <= ioctl_filesize;
                    end
                end
                LOAD: begin
                    if (fall_edge) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (start_q) pend_q <= 1'b1;
                    if (fifo_empty && !mem_req_q) begin
                        state_q    <= DONE;
                        rom_mask_q <= mask_d;
                        loading_q  <= 1'b0;
                        ready_q    <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_din  = mem_din_q;
    assign loading      = loading_q;
    assign ready        = ready_q;
    assign rom_mask     = rom_mask_q;
    assign overflow     = overflow_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_rom_loader.sv
module tb_rom_loader;
  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;
  logic [23:0] ioctl_filesize = '0;
  logic        loading, ready, overflow;
  logic [23:0] rom_mask;
  logic [1:0]  dbg_state;

  logic        ack_resp = 1'b0;
  logic        ack_stray = 1'b0;
  bit          ack_hold = 1'b0;
  int          ack_delay = 2;
  int          wait_cnt = 0;

  int          checks = 0;
  int          errors = 0;
  logic [39:0] exp_q[$];

  rom_loader_if bus();
  assign bus.mem_ack = ack_resp | ack_stray;

  rom_loader #(.ROM_INDEX(8'h00), .FIFO_DEPTH(4), .HDR_SIZE(512)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_filesize(ioctl_filesize), .mem(bus),
    .loading(loading), .ready(ready), .rom_mask(rom_mask),
    .overflow(overflow), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h", name, act, exp_v);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_dl(input logic [7:0] idx, input logic [23:0] fs);
    ioctl_index = idx;
    ioctl_filesize = fs;
    ioctl_download = 1'b1;
    repeat (3) tick();
  endtask

  task automatic strobe(input logic [24:0] a, input logic [15:0] d, input bit expect_w,
                        input logic [23:0] ea, input bit fall);
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (fall) ioctl_download = 1'b0;
    if (expect_w) exp_q.push_back({ea, d});
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check({name, "_ready"}, ready, 1'b1);
    check({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  // memory responder + scoreboard monitor: each acknowledged request is checked
  initial begin
    forever begin
      @(posedge clk_sys);
      #1;
      ack_resp = 1'b0;
      if (!reset_n || !bus.mem_req || ack_hold) begin
        wait_cnt = 0;
      end else begin
        wait_cnt++;
        if (wait_cnt >= ack_delay) begin
          check("write_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) check("mem_write", {bus.mem_addr, bus.mem_din}, exp_q.pop_front());
          ack_resp = 1'b1;
          wait_cnt = 0;
        end
      end
    end
  end

  // stimulus
  initial begin
    #1;
    check("rst_state", dbg_state, 2'd0);
    check("rst_outputs", {bus.mem_req, loading, ready, overflow, rom_mask, bus.mem_addr, bus.mem_din}, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // plain image, last word arrives with the download falling edge
    start_dl(8'h00, 24'h100000);
    check("t1_loading", loading, 1'b1);
    strobe(25'h000000, 16'h1111, 1, 24'h000000, 0);
    strobe(25'h000002, 16'h2222, 1, 24'h000002, 0);
    strobe(25'h000004, 16'h3333, 1, 24'h000004, 0);
    strobe(25'h000006, 16'h4444, 1, 24'h000006, 1);
    wait_done("t1");
    check("t1_mask", rom_mask, 24'h0FFFFF);
    check("t1_loading_off", loading, 1'b0);
    check("t1_overflow", overflow, 1'b0);
    check("t1_state", dbg_state, 2'd3);

    // foreign index: ignored entirely
    start_dl(8'h01, 24'h000100);
    check("t2_loading", loading, 1'b0);
    strobe(25'h000000, 16'hAAAA, 0, 24'h0, 0);
    check("t2_loading_b", loading, 1'b0);
    strobe(25'h000002, 16'hBBBB, 0, 24'h0, 1);
    repeat (5) tick();
    check("t2_ready_kept", ready, 1'b1);
    check("t2_state", dbg_state, 2'd3);
    check("t2_mask_kept", rom_mask, 24'h0FFFFF);
    check("t2_no_req", bus.mem_req, 1'b0);

    // copier header skipped
    start_dl(8'h00, 24'h080200);
    strobe(25'h0001FC, 16'h0A0A, 0, 24'h0, 0);
    strobe(25'h0001FE, 16'h0B0B, 0, 24'h0, 0);
    repeat (3) tick();
    check("t3_hdr_no_req", bus.mem_req, 1'b0);
    strobe(25'h000200, 16'hC0DE, 1, 24'h000000, 0);
    strobe(25'h000202, 16'hBEEF, 1, 24'h000002, 1);
    wait_done("t3");
    check("t3_mask", rom_mask, 24'h07FFFF);

    // non-power-of-two size
    start_dl(8'h00, 24'h300000);
    strobe(25'h000010, 16'h5555, 1, 24'h000010, 0);
    strobe(25'h000012, 16'h6666, 1, 24'h000012, 1);
    wait_done("t4");
    check("t4_mask", rom_mask, 24'h3FFFFF);

    // header only, empty payload
    start_dl(8'h00, 24'h000200);
    strobe(25'h000000, 16'h7777, 0, 24'h0, 1);
    wait_done("t5");
    check("t5_mask_zero", rom_mask, 24'h000000);

    // start during DRAIN is deferred until DONE
    ack_hold = 1'b1;
    start_dl(8'h00, 24'h001000);
    strobe(25'h000020, 16'h8888, 1, 24'h000020, 1);
    repeat (2) tick();
    start_dl(8'h00, 24'h000400);
    check("t6_still_drain", dbg_state, 2'd2);
    ack_hold = 1'b0;
    begin
      int n;
      n = 0;
      while (dbg_state !== 2'd1 && n < 50) begin
        tick();
        n++;
      end
    end
    check("t6_deferred_load", dbg_state, 2'd1);
    check("t6_first_drained", exp_q.size(), 0);
    check("t6_ready_cleared", ready, 1'b0);
    strobe(25'h000030, 16'h9999, 1, 24'h000030, 1);
    wait_done("t6");
    check("t6_mask", rom_mask, 24'h0003FF);

    // overflow: six back-to-back strobes while the memory stalls
    ack_hold = 1'b1;
    start_dl(8'h00, 24'h000010);
    strobe(25'h000000, 16'hA000, 1, 24'h000000, 0);
    strobe(25'h000002, 16'hA001, 1, 24'h000002, 0);
    strobe(25'h000004, 16'hA002, 1, 24'h000004, 0);
    strobe(25'h000006, 16'hA003, 1, 24'h000006, 0);
    strobe(25'h000008, 16'hA004, 1, 24'h000008, 0);
    strobe(25'h00000A, 16'hA005, 0, 24'h0, 0);
    repeat (14) tick();
    check("t7_overflow", overflow, 1'b1);
    check("t7_req_held", {bus.mem_req, bus.mem_addr, bus.mem_din}, {1'b1, 24'h000000, 16'hA000});
    ack_hold = 1'b0;
    end_dl();
    wait_done("t7");
    check("t7_overflow_sticky", overflow, 1'b1);
    check("t7_mask", rom_mask, 24'h00000F);

    // reset during DRAIN with a request outstanding
    ack_hold = 1'b1;
    start_dl(8'h00, 24'h000100);
    check("t8_overflow_cleared", overflow, 1'b0);
    strobe(25'h000040, 16'hD000, 1, 24'h000040, 0);
    strobe(25'h000042, 16'hD001, 1, 24'h000042, 1);
    repeat (2) tick();
    check("t8_in_drain", {dbg_state, bus.mem_req}, {2'd2, 1'b1});
    #2;
    reset_n = 1'b0;
    #1;
    check("t8_rst_state", dbg_state, 2'd0);
    check("t8_rst_outputs", {bus.mem_req, loading, ready, overflow, rom_mask, bus.mem_addr, bus.mem_din}, 0);
    exp_q.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    ack_hold = 1'b0;
    tick();
    ack_stray = 1'b1;
    tick();
    ack_stray = 1'b0;
    repeat (3) tick();
    check("t8_stray_ack_state", dbg_state, 2'd0);
    check("t8_stray_ack_outputs", {bus.mem_req, loading, ready}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter ROM_INDEX, default 8'h00: ioctl_index value that selects a ROM download; other indices are ignored.
REQ-002 Parameter FIFO_DEPTH, default 4: word FIFO entries, power of two, at least 2.
REQ-003 Parameter HDR_SIZE, default 512: copier-header length in bytes.
REQ-004 clk_sys  in  1  the single system clock; all logic is on its rising edge.
REQ-005 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 ioctl_download  in  1  download-active level from the loader interface.
REQ-007 ioctl_index  in  8  menu index of the current download.
REQ-008 ioctl_wr  in  1  one-cycle strobe for a 16-bit word.
REQ-009 ioctl_addr  in  25  byte address of the strobed word; always even.
REQ-010 ioctl_dout  in  16  strobed word, low byte at the even address.
REQ-011 ioctl_filesize  in  24  file size in bytes; stable before the ioctl_download rise.
REQ-012 mem_req  out  1  write request level to the memory controller.
REQ-013 mem_addr  out  24  byte address of the request.
REQ-014 mem_din  out  16  write data of the request.
REQ-015 mem_ack  in  1  one-cycle completion pulse from the memory controller.
REQ-016 loading  out  1  high in states LOAD and DRAIN.
REQ-017 ready  out  1  high in state DONE: image written and rom_mask valid.
REQ-018 rom_mask  out  24  address mask for the loaded payload.
REQ-019 overflow  out  1  sticky flag: a word was dropped on a full FIFO.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, DRAIN and DONE.
REQ-021 Download start is a 0->1 edge of ioctl_download with ioctl_index==ROM_INDEX, registered one cycle.
REQ-022 Download start SHALL be accepted from IDLE or DONE and move to LOAD.
REQ-023 On download start: clear the FIFO, clear overflow, clear ready, and latch hdr = (ioctl_filesize mod 1024 == HDR_SIZE).
REQ-024 Edges with any other ioctl_index SHALL be ignored with no state or output change.
REQ-025 In LOAD, each ioctl_wr with ioctl_addr >= (hdr ? HDR_SIZE : 0) SHALL push {ioctl_addr - offset, ioctl_dout} into the FIFO, truncated to 24 bits; other words SHALL be discarded.
REQ-026 In LOAD, the 1->0 edge of ioctl_download SHALL move to DRAIN; a same-cycle ioctl_wr is still pushed.
REQ-027 A push into a full FIFO SHALL succeed if a pop occurs in the same cycle.
REQ-028 Otherwise a push into a full FIFO SHALL be dropped and set overflow.
REQ-029 Issue rule: when mem_req=0 and the FIFO is non-empty in LOAD or DRAIN, pop the head into mem_addr/mem_din and set mem_req=1 on the next edge.
REQ-030 mem_req, mem_addr and mem_din SHALL hold until mem_ack is sampled high.
REQ-031 mem_req SHALL fall on the edge after mem_ack is sampled high; a new issue is allowed one cycle later.
REQ-032 mem_ack SHALL be ignored while mem_req=0.
REQ-033 Words SHALL be written to memory in arrival order.
REQ-034 In DRAIN, once the FIFO is empty and mem_req=0, the FSM SHALL register rom_mask and enter DONE.
REQ-035 rom_mask SHALL be the bit-smear of (P-1), i.e. all bits at and below its MSB set, where P = filesize - (hdr ? HDR_SIZE : 0).
REQ-036 If P==0, rom_mask SHALL be 0.
REQ-037 A download start while in DRAIN SHALL be deferred until DONE is reached.

Reset
REQ-038 reset_n low SHALL immediately force IDLE, empty the FIFO, and set mem_req, loading, ready, overflow, rom_mask, mem_addr and mem_din to 0.
REQ-039 Reset mid-transfer SHALL abandon the outstanding request; a later mem_ack SHALL be ignored.
REQ-040 After reset release, the FSM SHALL wait in IDLE for a new download start.

Verification
REQ-041 filesize 0x100000, ROM_INDEX, mem_ack 2 cycles after each request -> mem_addr sequence equals ioctl_addr sequence, then ready=1 and rom_mask=0x0FFFFF.
REQ-042 filesize 0x080200 -> addresses 0x000-0x1FE produce no mem_req; address 0x200 writes mem_addr 0x000000; rom_mask=0x07FFFF.
REQ-043 filesize 0x300000 -> rom_mask=0x3FFFFF.
REQ-044 mem_ack held low 20 cycles while 6 strobes arrive with FIFO_DEPTH 4 -> overflow=1; first 5 words (1 in flight + 4 queued) written in order; 6th never written.
REQ-045 ioctl_index=1 download -> no mem_req, loading stays 0, ready keeps its prior value.
REQ-046 reset_n pulsed low in DRAIN with mem_req=1 -> all outputs 0 at once; a stray mem_ack afterwards causes no state change.
